// File: rtl/pe_alu_pipe_if.sv
// Operand/result bundle for pe_alu_pipe: operands, op select, accumulator clear and result.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready, and ready never looks at valid.
interface pe_alu_pipe_if #(
    parameter int WIDTH        = 32,
    parameter int NoConfigBits = 4
);
    logic [WIDTH-1:0]        data_in1;
    logic [WIDTH-1:0]        data_in2;
    logic [WIDTH-1:0]        data_in3;
    logic                    in_valid;
    logic                    in_ready;
    logic                    acc_clr;
    logic [WIDTH-1:0]        data_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [NoConfigBits-1:0] ALU_func;

    modport master (
        output data_in1, data_in2, data_in3, in_valid, acc_clr, out_ready, ALU_func,
        input  in_ready, data_out, out_valid
    );

    modport slave (
        input  data_in1, data_in2, data_in3, in_valid, acc_clr, out_ready, ALU_func,
        output in_ready, data_out, out_valid
    );
endinterface

// File: rtl/pe_alu_pipe.sv
// Pipelined, flow-controlled PE ALU with multiply-accumulate register and full backpressure.
// Optional macro PE_ALU_SAT_EN: signed saturating ADD/SUB/MUL_ADD/MAC instead of wrapping.
module pe_alu_pipe #(
    parameter int WIDTH        = 32,
    parameter int LATENCY      = 2,
    parameter int NoConfigBits = 4
) (
    input  logic         clk,
    input  logic         rst,
    pe_alu_pipe_if.slave bus
);
    localparam logic [NoConfigBits-1:0] OP_ADD     = NoConfigBits'(0);
    localparam logic [NoConfigBits-1:0] OP_SUB     = NoConfigBits'(1);
    localparam logic [NoConfigBits-1:0] OP_AND     = NoConfigBits'(2);
    localparam logic [NoConfigBits-1:0] OP_OR      = NoConfigBits'(3);
    localparam logic [NoConfigBits-1:0] OP_XOR     = NoConfigBits'(4);
    localparam logic [NoConfigBits-1:0] OP_MUL     = NoConfigBits'(5);
    localparam logic [NoConfigBits-1:0] OP_MUL_ADD = NoConfigBits'(6);
    localparam logic [NoConfigBits-1:0] OP_MAC     = NoConfigBits'(7);

    logic [WIDTH-1:0]   a, b, c;
    logic [WIDTH-1:0]   acc, acc_base;
    logic [WIDTH-1:0]   add_res, sub_res, mul_res, mad_res, mac_res, result;
    logic               accept;
    logic [LATENCY-1:0] stg_valid;
    logic [LATENCY-1:0] load;
    logic [WIDTH-1:0]   stg_data [LATENCY];

    assign a = bus.data_in1;
    assign b = bus.data_in2;
    assign c = bus.data_in3;

    // A clear arriving with a MAC beat replaces the old accumulator by zero.
    assign acc_base = bus.acc_clr ? '0 : acc;

`ifdef PE_ALU_SAT_EN
    // Wide enough for a full signed product plus one addend without overflow.
    localparam int EXT = 2*WIDTH + 2;
    localparam logic signed [EXT-1:0] SAT_MAX = {{(EXT-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EXT-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [EXT-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(EXT-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [EXT-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
        else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        else                  return v[WIDTH-1:0];
    endfunction

    logic signed [EXT-1:0] sprod;
    assign sprod   = sext(a) * sext(b);
    assign add_res = sat(sext(a) + sext(b));
    assign sub_res = sat(sext(a) - sext(b));
    assign mul_res = sprod[WIDTH-1:0];
    assign mad_res = sat(sprod + sext(c));
    assign mac_res = sat(sext(acc_base) + sprod);
`else
    assign add_res = a + b;
    assign sub_res = a - b;
    assign mul_res = a * b;
    assign mad_res = a * b + c;
    assign mac_res = acc_base + a * b;
`endif

    always_comb begin
        result = '0;
        case (bus.ALU_func)
            OP_ADD:     result = add_res;
            OP_SUB:     result = sub_res;
            OP_AND:     result = a & b;
            OP_OR:      result = a | b;
            OP_XOR:     result = a ^ b;
            OP_MUL:     result = mul_res;
            OP_MUL_ADD: result = mad_res;
            OP_MAC:     result = mac_res;
            default:    result = '0;
        endcase
    end

    // load[k]: stage k takes new content this edge (it is empty or its content moves on).
    always_comb begin
        load = '0;
        load[LATENCY-1] = !stg_valid[LATENCY-1] || bus.out_ready;
        for (int k = LATENCY-2; k >= 0; k--) begin
            load[k] = !stg_valid[k] || load[k+1];
        end
    end

    assign bus.in_ready  = load[0] && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = stg_valid[LATENCY-1];
    assign bus.data_out  = stg_data[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= '0;
            for (int k = 0; k < LATENCY; k++) stg_data[k] <= '0;
            acc <= '0;
        end else begin
            if (load[0]) begin
                stg_valid[0] <= accept;
                if (accept) stg_data[0] <= result;
            end
            // Data words only move with valid beats so an empty stage keeps its last word.
            for (int k = 1; k < LATENCY; k++) begin
                if (load[k]) begin
                    stg_valid[k] <= stg_valid[k-1];
                    if (stg_valid[k-1]) stg_data[k] <= stg_data[k-1];
                end
            end
            if (accept && bus.ALU_func == OP_MAC) acc <= mac_res;
            else if (bus.acc_clr)                  acc <= '0;
        end
    end
endmodule

// File: tb/tb_pe_alu_pipe.sv
// Directed bench for pe_alu_pipe: 32-bit/2-stage instance for function and flow control,
// 8-bit/1-stage instance for the wrap-versus-saturate corner cases.
module tb_pe_alu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_alu_pipe_if #(.WIDTH(32), .NoConfigBits(4)) bus ();
  pe_alu_pipe_if #(.WIDTH(8),  .NoConfigBits(4)) bus8 ();

  pe_alu_pipe #(.WIDTH(32), .LATENCY(2), .NoConfigBits(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pe_alu_pipe #(.WIDTH(8), .LATENCY(1), .NoConfigBits(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

`ifdef PE_ALU_SAT_EN
  localparam logic [7:0] EXP8_ADD  = 8'h7F;
  localparam logic [7:0] EXP8_SUB  = 8'h80;
  localparam logic [7:0] EXP8_MAC2 = 8'h7F;
  localparam logic [7:0] EXP8_MAC3 = 8'h7F;
`else
  localparam logic [7:0] EXP8_ADD  = 8'h80;
  localparam logic [7:0] EXP8_SUB  = 8'h7F;
  localparam logic [7:0] EXP8_MAC2 = 8'hC8;
  localparam logic [7:0] EXP8_MAC3 = 8'hC8;
`endif

  typedef struct {
    logic [3:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        clr;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic clr, input logic [31:0] e);
    vec_t v;
    v.func = f; v.a = a; v.b = b; v.c = c; v.clr = clr; v.exp = e;
    vecs.push_back(v);
  endtask

  // Scoreboard: every output transfer pops the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=0x%0h required=none", bus.data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.data_out !== mon_exp) begin
          failures++;
          $display("FAIL output_data actual=0x%0h required=0x%0h", bus.data_out, mon_exp);
        end
      end
    end
  end

  // Driver tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic clr, input logic [31:0] e);
    int n;
    bus.ALU_func = f; bus.data_in1 = a; bus.data_in2 = b; bus.data_in3 = c;
    bus.acc_clr = clr; bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic op8(input string name, input logic [3:0] f, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] e);
    bus8.ALU_func = f; bus8.data_in1 = a; bus8.data_in2 = b; bus8.in_valid = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus8.out_valid), 32'd1);
    chk(name, 32'(bus8.data_out), 32'(e));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    add_vec(4'd0,  32'h0000_1234, 32'h0000_1111, 32'd0,   1'b0, 32'h0000_2345);
    add_vec(4'd0,  32'hFFFF_FFFF, 32'd2,         32'd0,   1'b0, 32'd1);
    add_vec(4'd1,  32'd3,         32'd5,         32'd0,   1'b0, 32'hFFFF_FFFE);
    add_vec(4'd1,  32'd1000,      32'd1,         32'd0,   1'b0, 32'd999);
    add_vec(4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'd0,   1'b0, 32'h00F0_1200);
    add_vec(4'd3,  32'hF0F0_0000, 32'h0F00_00FF, 32'd0,   1'b0, 32'hFFF0_00FF);
    add_vec(4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'd0,   1'b0, 32'h5555_5555);
    add_vec(4'd5,  32'd1234,      32'd5678,      32'd0,   1'b0, 32'd7006652);
    add_vec(4'd5,  32'h0001_0000, 32'h0001_0000, 32'd0,   1'b0, 32'd0);
    add_vec(4'd5,  32'hFFFF_FFFF, 32'd3,         32'd0,   1'b0, 32'hFFFF_FFFD);
    add_vec(4'd6,  32'd6,         32'd7,         32'd100, 1'b0, 32'd142);
    add_vec(4'd6,  32'hFFFF_FFFF, 32'd5,         32'd10,  1'b0, 32'd5);
    add_vec(4'd8,  32'd9,         32'd9,         32'd0,   1'b0, 32'd0);
    add_vec(4'd15, 32'hFFFF_FFFF, 32'd1,         32'd0,   1'b0, 32'd0);
    add_vec(4'd7,  32'd2,         32'd3,         32'd0,   1'b0, 32'd6);
    add_vec(4'd7,  32'd4,         32'd5,         32'd0,   1'b0, 32'd26);
    add_vec(4'd7,  32'd1,         32'd1,         32'd0,   1'b1, 32'd1);
    add_vec(4'd7,  32'd2,         32'd2,         32'd0,   1'b0, 32'd5);
    add_vec(4'd0,  32'd1,         32'd1,         32'd0,   1'b0, 32'd2);
    add_vec(4'd7,  32'd1,         32'd1,         32'd0,   1'b0, 32'd6);
    add_vec(4'd0,  32'd1,         32'd1,         32'd0,   1'b1, 32'd2);
    add_vec(4'd7,  32'd2,         32'd5,         32'd0,   1'b0, 32'd10);

    // Reset with garbage offered on both instances.
    bus.ALU_func = 4'd0; bus.data_in1 = 32'd99; bus.data_in2 = 32'd99; bus.data_in3 = 32'd0;
    bus.acc_clr = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus8.ALU_func = 4'd0; bus8.data_in1 = 8'd0; bus8.data_in2 = 8'd0; bus8.data_in3 = 8'd0;
    bus8.acc_clr = 1'b0; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data_out", bus.data_out, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst8_out_valid", 32'(bus8.out_valid), 32'd0);
    @(posedge clk); #1;

    // Latency: ADD 5+7 accepted at edge t shows up after edge t+1.
    bus.ALU_func = 4'd0; bus.data_in1 = 32'd5; bus.data_in2 = 32'd7; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(32'd12);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_on_time", 32'(bus.out_valid), 32'd1);
    chk("lat_data", bus.data_out, 32'd12);
    @(posedge clk); #1;
    drain();

    // Table of ops streamed back to back.
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].clr, vecs[i].exp);
    end
    drain();

    // Clear with no beat, then MAC starts from zero.
    bus.acc_clr = 1'b1;
    @(posedge clk); #1;
    bus.acc_clr = 1'b0;
    send(4'd7, 32'd3, 32'd4, 32'd0, 1'b0, 32'd12);
    drain();

    // Streaming: 8 SUB beats, one output per cycle, in_ready never drops.
    for (int i = 0; i < 8; i++) begin
      bus.ALU_func = 4'd1; bus.data_in1 = 32'(100 + i); bus.data_in2 = 32'(i);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (i >= 2) chk("stream_out_valid", 32'(bus.out_valid), 32'd1);
      exp_q.push_back(32'd100);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_tail6", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_tail7", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    // Backpressure: two beats fill the pipe, third is refused, output held.
    bus.out_ready = 1'b0;
    bus.ALU_func = 4'd0; bus.data_in1 = 32'd10; bus.data_in2 = 32'd1; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept_a", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(32'd11);
    @(posedge clk); #1;
    bus.data_in1 = 32'd20; bus.data_in2 = 32'd2;
    @(negedge clk);
    chk("bp_accept_b", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(32'd22);
    @(posedge clk); #1;
    bus.data_in1 = 32'd30; bus.data_in2 = 32'd3;
    @(negedge clk);
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_data", bus.data_out, 32'd11);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_data", bus.data_out, 32'd11);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(32'd33);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();

    // Mid-stream reset with two MAC beats in flight.
    bus.out_ready = 1'b0;
    bus.ALU_func = 4'd7; bus.data_in1 = 32'd5; bus.data_in2 = 32'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("midrst_data_out", bus.data_out, 32'd0);
    send(4'd7, 32'd3, 32'd3, 32'd0, 1'b0, 32'd9);
    drain();

    // 8-bit wrap versus saturate.
    op8("w8_add", 4'd0, 8'd127, 8'd1, EXP8_ADD);
    op8("w8_sub", 4'd1, 8'h80, 8'd1, EXP8_SUB);
    op8("w8_mac1", 4'd7, 8'd10, 8'd10, 8'd100);
    op8("w8_mac2", 4'd7, 8'd10, 8'd10, EXP8_MAC2);
    op8("w8_mac3", 4'd7, 8'd0, 8'd0, EXP8_MAC3);
    op8("w8_mul", 4'd5, 8'd16, 8'd17, 8'h10);

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
